// File: rtl/decode_pkg.sv
// Shared constants for the decode stage: field codes, ALU codes, operand selects and FSM states.
package decode_pkg;

    localparam logic [1:0] SEC_LS     = 2'd3;

    localparam logic [2:0] ALU_ADD    = 3'd0;
    localparam logic [2:0] ALU_SUB    = 3'd1;
    localparam logic [2:0] ALU_AND    = 3'd2;
    localparam logic [2:0] ALU_OR     = 3'd3;
    localparam logic [2:0] ALU_XOR    = 3'd4;
    localparam logic [2:0] ALU_NOT    = 3'd5;
    localparam logic [2:0] ALU_LD     = 3'd6;
    localparam logic [2:0] ALU_DEF    = 3'd7;

    localparam logic [2:0] LS_LD_R    = 3'd0;
    localparam logic [2:0] LS_LD_DM   = 3'd1;
    localparam logic [2:0] LS_LD_IMD  = 3'd2;
    localparam logic [2:0] LS_ST_R    = 3'd3;
    localparam logic [2:0] LS_ST_DM   = 3'd4;
    localparam logic [2:0] LS_LDX_IMD = 3'd5;

    localparam logic [1:0] SEL_REG    = 2'd0;
    localparam logic [1:0] SEL_DM     = 2'd1;
    localparam logic [1:0] SEL_IMD    = 2'd2;

    localparam logic [4:0] OP_LDX_IMD = {SEC_LS, LS_LDX_IMD};

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EXT  = 1'b1
    } state_t;

    // Instruction word: 5-bit opcode, register number, 8-bit immediate.
    function automatic int ins_width(input int rsel_w);
        return 5 + rsel_w + 8;
    endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Instruction-in / decoded-bundle-out handshake bundle for the decode stage.
interface decode_stage_if
    import decode_pkg::*;
#(
    parameter int NUM_REGS = 4,
    parameter int DATA_W   = 16
) ();
    localparam int RSEL_W = $clog2(NUM_REGS);
    localparam int INS_W  = ins_width(RSEL_W);

    logic                in_valid;
    logic                in_ready;
    logic [INS_W-1:0]    ins;
    logic                flush;
    logic                out_valid;
    logic                out_ready;
    logic                data_mem_ce;
    logic                reg_ce;
    logic                carry_ce;
    logic                accu_ce;
    logic                illegal;
    logic [NUM_REGS-1:0] reg_addr;
    logic [1:0]          sel;
    logic [2:0]          alu_code;
    logic [DATA_W-1:0]   data;

    modport master (
        output in_valid, ins, flush, out_ready,
        input  in_ready, out_valid, data_mem_ce, reg_ce, carry_ce, accu_ce,
        input  illegal, reg_addr, sel, alu_code, data
    );

    modport slave (
        input  in_valid, ins, flush, out_ready,
        output in_ready, out_valid, data_mem_ce, reg_ce, carry_ce, accu_ce,
        output illegal, reg_addr, sel, alu_code, data
    );
endinterface

// File: rtl/decode_comb.sv
// Purely combinational field decode of one instruction word into a control bundle.
module decode_comb
    import decode_pkg::*;
#(
    parameter int NUM_REGS = 4,
    parameter int DATA_W   = 16,
    parameter int RSEL_W   = $clog2(NUM_REGS),
    parameter int INS_W    = ins_width(RSEL_W)
) (
    input  logic [INS_W-1:0]    ins_i,
    output logic [1:0]          sel_o,
    output logic [2:0]          alu_code_o,
    output logic                carry_ce_o,
    output logic                accu_ce_o,
    output logic                reg_ce_o,
    output logic                data_mem_ce_o,
    output logic                illegal_o,
    output logic                two_word_o,
    output logic [NUM_REGS-1:0] reg_addr_o,
    output logic [DATA_W-1:0]   data_o
);
    // LDX_IMD only has somewhere to put a second byte when data is wider than 8 bits.
    localparam bit HAS_EXT = (DATA_W > 8);

    logic [4:0]        opcode;
    logic [1:0]        section;
    logic [2:0]        rest;
    logic [RSEL_W-1:0] rnum;
    logic [7:0]        imm;
    logic              cc, ac, rc, dm, ill;

    assign opcode  = ins_i[INS_W-1 -: 5];
    assign section = opcode[4:3];
    assign rest    = opcode[2:0];
    assign rnum    = ins_i[8 +: RSEL_W];
    assign imm     = ins_i[7:0];

    always_comb begin
        sel_o      = SEL_REG;
        alu_code_o = ALU_DEF;
        cc         = 1'b0;
        ac         = 1'b0;
        rc         = 1'b0;
        dm         = 1'b0;
        ill        = 1'b0;
        two_word_o = 1'b0;
        if (section != SEC_LS) begin
            sel_o = section;
            if (rest <= ALU_NOT) begin
                alu_code_o = rest;
                ac         = 1'b1;
                cc         = (rest <= ALU_SUB);
            end else begin
                ill = 1'b1;
            end
        end else begin
            case (rest)
                LS_LD_R:    begin alu_code_o = ALU_LD; ac = 1'b1; end
                LS_LD_DM:   begin sel_o = SEL_DM;  alu_code_o = ALU_LD; ac = 1'b1; end
                LS_LD_IMD:  begin sel_o = SEL_IMD; alu_code_o = ALU_LD; ac = 1'b1; end
                LS_ST_R:    rc = 1'b1;
                LS_ST_DM:   begin sel_o = SEL_DM; dm = 1'b1; end
                LS_LDX_IMD: begin
                    sel_o      = SEL_IMD;
                    alu_code_o = ALU_LD;
                    ac         = 1'b1;
                    two_word_o = HAS_EXT;
                    ill        = !HAS_EXT;
                end
                default:    ill = 1'b1;
            endcase
        end
    end

    // Illegal bundles still flow downstream but must not enable anything.
    assign carry_ce_o    = cc && !ill;
    assign accu_ce_o     = ac && !ill;
    assign reg_ce_o      = rc && !ill;
    assign data_mem_ce_o = dm && !ill;
    assign illegal_o     = ill;
    assign data_o        = DATA_W'(imm);

    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_onehot
        assign reg_addr_o[gi] = (rnum == RSEL_W'(gi));
    end
endmodule

// File: rtl/decode_stage.sv
// Decode stage: accepts instruction words, merges two-word LDX_IMD, and presents
// one registered control bundle per instruction with valid/ready flow control.
module decode_stage
    import decode_pkg::*;
#(
    parameter int NUM_REGS = 4,
    parameter int DATA_W   = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    decode_stage_if.slave bus
);
    localparam int RSEL_W = $clog2(NUM_REGS);
    localparam int INS_W  = ins_width(RSEL_W);

    state_t              state_q;
    logic [INS_W-1:0]    hold_q;
    logic                out_valid_q;
    logic                data_mem_ce_q, reg_ce_q, carry_ce_q, accu_ce_q, illegal_q;
    logic [NUM_REGS-1:0] reg_addr_q;
    logic [1:0]          sel_q;
    logic [2:0]          alu_code_q;
    logic [DATA_W-1:0]   data_q;

    logic                accept;
    logic [INS_W-1:0]    dec_ins_d;
    logic                data_mem_ce_d, reg_ce_d, carry_ce_d, accu_ce_d, illegal_d, two_word_d;
    logic [NUM_REGS-1:0] reg_addr_d;
    logic [1:0]          sel_d;
    logic [2:0]          alu_code_d;
    logic [DATA_W-1:0]   dec_data_d;
    logic [DATA_W-1:0]   data_d;

    assign bus.in_ready = rst_n && !bus.flush && (!out_valid_q || bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready;

    // In EXT the bundle comes from the held first word; the second word only supplies data.
    assign dec_ins_d = (state_q == ST_EXT) ? hold_q : bus.ins;

    decode_comb #(
        .NUM_REGS (NUM_REGS),
        .DATA_W   (DATA_W)
    ) u_decode_comb (
        .ins_i         (dec_ins_d),
        .sel_o         (sel_d),
        .alu_code_o    (alu_code_d),
        .carry_ce_o    (carry_ce_d),
        .accu_ce_o     (accu_ce_d),
        .reg_ce_o      (reg_ce_d),
        .data_mem_ce_o (data_mem_ce_d),
        .illegal_o     (illegal_d),
        .two_word_o    (two_word_d),
        .reg_addr_o    (reg_addr_d),
        .data_o        (dec_data_d)
    );

    if (DATA_W > 8) begin : g_ext_data
        assign data_d = (state_q == ST_EXT) ? {bus.ins[DATA_W-9:0], dec_data_d[7:0]} : dec_data_d;
    end else begin : g_byte_data
        assign data_d = dec_data_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            hold_q        <= '0;
            out_valid_q   <= 1'b0;
            data_mem_ce_q <= 1'b0;
            reg_ce_q      <= 1'b0;
            carry_ce_q    <= 1'b0;
            accu_ce_q     <= 1'b0;
            illegal_q     <= 1'b0;
            reg_addr_q    <= '0;
            sel_q         <= SEL_REG;
            alu_code_q    <= ALU_DEF;
            data_q        <= '0;
        end else if (bus.flush) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
        end else begin
            if (out_valid_q && bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
            if (accept) begin
                if (state_q == ST_IDLE && two_word_d) begin
                    state_q <= ST_EXT;
                    hold_q  <= bus.ins;
                end else begin
                    state_q       <= ST_IDLE;
                    out_valid_q   <= 1'b1;
                    data_mem_ce_q <= data_mem_ce_d;
                    reg_ce_q      <= reg_ce_d;
                    carry_ce_q    <= carry_ce_d;
                    accu_ce_q     <= accu_ce_d;
                    illegal_q     <= illegal_d;
                    reg_addr_q    <= reg_addr_d;
                    sel_q         <= sel_d;
                    alu_code_q    <= alu_code_d;
                    data_q        <= data_d;
                end
            end
        end
    end

    assign bus.out_valid   = out_valid_q;
    assign bus.data_mem_ce = data_mem_ce_q;
    assign bus.reg_ce      = reg_ce_q;
    assign bus.carry_ce    = carry_ce_q;
    assign bus.accu_ce     = accu_ce_q;
    assign bus.illegal     = illegal_q;
    assign bus.reg_addr    = reg_addr_q;
    assign bus.sel         = sel_q;
    assign bus.alu_code    = alu_code_q;
    assign bus.data        = data_q;
endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameter NUM_REGS, default 4, meaning register count (power of two, 2..16); RSEL_W = log2(NUM_REGS).
REQ-002 SHALL have parameter DATA_W, default 16, meaning data/immediate width (8..16); INS_W = 5 + RSEL_W + 8.
REQ-003 SHALL have port clk  in  1  meaning the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  in  1  meaning reset; synchronous, active-low.
REQ-005 SHALL have ports in_valid  in  1, in_ready  out  1, ins  in  INS_W  meaning the instruction word handshake.
REQ-006 SHALL have port flush  in  1  meaning discard the held and pending decode.
REQ-007 SHALL have ports out_valid  out  1, out_ready  in  1  meaning the decoded-bundle handshake.
REQ-008 SHALL have ports data_mem_ce, reg_ce, carry_ce, accu_ce, illegal  out  1 each; reg_addr  out  NUM_REGS (one-hot); sel  out  2; alu_code  out  3; data  out  DATA_W.

Function
REQ-009 SHALL decode fields: opcode = ins[INS_W-1 -: 5], section = opcode[4:3], rest = opcode[2:0], rnum = next RSEL_W bits, imm = ins[7:0].
REQ-010 SHALL, for section != 3, give sel = section; alu_code = rest for rest <= 5 (ADD0 SUB1 AND2 OR3 XOR4 NOT5), else 7 (DEF) with illegal = 1.
REQ-011 SHALL give carry_ce = 1 only for section != 3 with rest <= 1; accu_ce = 1 for section != 3 with rest <= 5.
REQ-012 SHALL, for section 3, decode rest: 0 LD_R (sel 0), 1 LD_DM (sel 1), 2 LD_IMD (sel 2), 3 ST_R (sel 0, reg_ce), 4 ST_DM (sel 1, data_mem_ce), 5 LDX_IMD (sel 2); rest 6/7 give illegal = 1, sel 0.
REQ-013 SHALL give alu_code 6 (LD) and accu_ce = 1 for section 3 with rest 0, 1, 2 or 5, and alu_code 7 for all other section-3 codes.
REQ-014 SHALL drive reg_addr = one-hot of rnum; data = zero-extended imm for single-word instructions.
REQ-015 SHALL force every CE output to 0 whenever illegal = 1 (illegal bundles are still delivered).
REQ-016 SHALL treat LDX_IMD as two words: first word held in state EXT, nothing output; second word's ins[DATA_W-9:0] becomes data[DATA_W-1:8]; when DATA_W = 8, LDX_IMD is illegal and single-word.
REQ-017 SHALL implement FSM IDLE -> EXT on accepted LDX_IMD word; EXT -> IDLE on accepted second word (no decode of the second word's opcode); flush -> IDLE from either state.
REQ-018 SHALL hold all outputs in one output register: out_valid rises the cycle after the final word is accepted (latency 1).
REQ-019 SHALL drive in_ready = !flush && (!out_valid || out_ready), allowing full throughput of one word per cycle.
REQ-020 SHALL hold the output bundle stable while out_valid && !out_ready.
REQ-021 SHALL, on flush, clear out_valid next cycle and discard any EXT first word, taking precedence over a simultaneous transfer.

Reset
REQ-022 SHALL, with rst_n low at a clock edge, set state IDLE, out_valid 0, all CE 0, illegal 0, reg_addr 0, sel 0, alu_code 7, data 0; reset mid-EXT discards the first word.
REQ-023 SHALL drive in_ready = 0 while rst_n is low.

Structure
REQ-024 SHALL take opcode, section, ALU code and sel constants plus the FSM state enum from shared package decode_pkg.
REQ-025 SHALL place the combinational field decode in sub-module decode_comb; decode_stage holds the FSM, holding register and output register.

Verification
REQ-026 SHALL cover: ADD R2 (opcode 0, rnum 2), out_ready = 1 -> next cycle out_valid, alu_code 0, carry_ce 1, accu_ce 1, reg_addr 4'b0100.
REQ-027 SHALL cover: LDX_IMD imm 0x34, then second word low byte 0x12, DATA_W 16 -> single bundle, data 0x1234, alu_code 6, sel 2, out_valid only after the second word.
REQ-028 SHALL cover: ST_DM with out_ready held 0 for 3 cycles -> bundle stable, in_ready 0, data_mem_ce 1 delivered exactly once.
REQ-029 SHALL cover: opcode 5'b00110 -> illegal 1, alu_code 7, all CE 0.
REQ-030 SHALL cover: flush asserted while in EXT -> state IDLE, next word decoded as a fresh instruction; rst_n low mid-stream -> all outputs at REQ-022 values.
